// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// Handshake: a byte moves on the rising clk edge where in_valid && in_ready. The driver keeps in_data stable while in_valid is high and the byte is not yet taken.
interface imem_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed little-endian byte stream and writes it word by word into instruction memory.
// Words past NUM_INST are drained from the stream but not written, and they raise the sticky error flag.
module imem_loader #(
  parameter int NUM_INST = 128
) (
  input  logic        clk,
  input  logic        reset,
  imem_loader_if.slave bus,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [31:0] DEPTH = NUM_INST;

  logic [2:0]  state;
  logic [2:0]  state_d;
  logic [15:0] len_q;
  logic [15:0] word_idx;
  logic [1:0]  byte_sel;
  logic [31:0] asm_q;
  logic        done_q;
  logic        error_q;

  logic        in_ready_int;
  logic        accept;
  logic        start_ok;
  logic [15:0] len_full;
  logic        in_range;
  logic        last_word;

  assign in_ready_int = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign accept       = bus.in_valid && in_ready_int;
  assign start_ok     = bus.start && ((state == S_IDLE) || (state == S_DONE));
  // Full count as it becomes known in the cycle the high byte is taken.
  assign len_full     = {bus.in_data, len_q[7:0]};
  assign in_range     = {16'd0, word_idx} < DEPTH;
  assign last_word    = (word_idx == (len_q - 16'd1));

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (bus.start) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) state_d = S_LEN_HI;
      S_LEN_HI: if (accept) state_d = (len_full == 16'd0) ? S_DONE : S_DATA;
      S_DATA:   if (accept && (byte_sel == 2'd3)) state_d = S_WRITE;
      S_WRITE:  state_d = last_word ? S_DONE : S_DATA;
      S_DONE:   if (bus.start) state_d = S_LEN_LO;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      len_q    <= 16'd0;
      word_idx <= 16'd0;
      byte_sel <= 2'd0;
      asm_q    <= 32'd0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state <= state_d;
      if (start_ok) begin
        word_idx <= 16'd0;
        byte_sel <= 2'd0;
        done_q   <= 1'b0;
        error_q  <= 1'b0;
      end
      case (state)
        S_LEN_LO: begin
          if (accept) len_q[7:0] <= bus.in_data;
        end
        S_LEN_HI: begin
          if (accept) begin
            len_q[15:8] <= bus.in_data;
            if (len_full == 16'd0) done_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_q[{byte_sel, 3'b000} +: 8] <= bus.in_data;
            byte_sel <= byte_sel + 2'd1;
          end
        end
        S_WRITE: begin
          // Overflow words still advance the index so the count of consumed words stays exact.
          word_idx <= word_idx + 16'd1;
          if (!in_range) error_q <= 1'b1;
          if (last_word) done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_int;
  assign bus.wr_en    = (state == S_WRITE) && in_range;
  assign bus.wr_addr  = (state == S_WRITE) ? {14'd0, word_idx, 2'b00} : 32'd0;
  assign bus.wr_data  = (state == S_WRITE) ? asm_q : 32'd0;
  assign bus.busy     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA) || (state == S_WRITE);
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-level reference model of the load protocol, per-cycle compare,
// directed scenarios with literal expectations, then randomized loads.
module tb_imem_loader;
  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;

  imem_loader_if bus();

  imem_loader #(.NUM_INST(NI)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] wlog[$];
  logic [31:0] tx_words[$];
  logic [7:0]  sq[$];

  // reference model: session progress counted in bytes of the stream
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_error = 1'b0;
  bit          m_pend = 1'b0;
  logic [15:0] m_n = 16'd0;
  logic [15:0] m_idx = 16'd0;
  int          m_bytes = 0;
  logic [31:0] m_word = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int k;
    if (reset) begin
      m_busy = 0; m_done = 0; m_error = 0; m_pend = 0;
      m_idx = 0; m_bytes = 0; m_word = 0;
      exp_q.delete();
    end else if (m_pend) begin
      m_pend = 0;
      if (m_idx >= 16'(NI)) m_error = 1;
      m_idx = m_idx + 16'd1;
      if (m_idx == m_n) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1; m_done = 0; m_error = 0;
        m_idx = 0; m_bytes = 0;
      end
    end else if (bus.in_valid) begin
      if (m_bytes == 0) begin
        m_n[7:0] = bus.in_data;
      end else if (m_bytes == 1) begin
        m_n[15:8] = bus.in_data;
        if (m_n == 16'd0) begin
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        k = (m_bytes - 2) % 4;
        m_word[k*8 +: 8] = bus.in_data;
        if (k == 3) begin
          m_pend = 1;
          if (m_idx < 16'(NI)) exp_q.push_back({32'(m_idx) * 32'd4, m_word});
        end
      end
      m_bytes++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle compare of every output against the model
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    chk("in_ready", 64'(bus.in_ready), 64'(m_busy && !m_pend));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("error", 64'(bus.error), 64'(m_error));
    chk("wr_en", 64'(bus.wr_en), 64'(m_pend && (m_idx < 16'(NI))));
    if (bus.wr_en === 1'b1) begin
      wlog.push_back({bus.wr_addr, bus.wr_data});
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {bus.wr_addr, bus.wr_data}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr_data", {bus.wr_addr, bus.wr_data}, e);
      end
    end
  end

  task automatic build_stream(input int n);
    sq.delete();
    sq.push_back(8'(n));
    sq.push_back(8'(n >> 8));
    foreach (tx_words[i])
      for (int b = 0; b < 4; b++) sq.push_back(tx_words[i][b*8 +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 0;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    @(negedge clk);
    while ($urandom_range(0, 99) < gap) begin
      bus.in_valid = 0;
      bus.in_data = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1;
    bus.in_data = b;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready stuck low, required high within 50 cycles");
    end
    @(posedge clk);
  endtask

  task automatic send_range(input int from, input int to, input int gap);
    for (int i = from; i < to; i++) send_byte(sq[i], gap);
  endtask

  task automatic wait_idle();
    int guard;
    @(negedge clk);
    bus.in_valid = 0;
    guard = 0;
    while (bus.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy stuck high, required low within 200 cycles");
    end
    repeat (2) @(negedge clk);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_load(input int n, input int gap);
    build_stream(n);
    wlog.delete();
    pulse_start();
    send_range(0, sq.size(), gap);
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    bus.start = 0;
    bus.in_valid = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic set_basic();
    tx_words.delete();
    tx_words.push_back(32'h00400293);
    tx_words.push_back(32'h45678337);
  endtask

  task automatic check_basic(input string tag);
    chk({tag, "_nwr"}, 64'(wlog.size()), 64'd2);
    chk({tag, "_wr0"}, wlog[0], {32'h0, 32'h00400293});
    chk({tag, "_wr1"}, wlog[1], {32'h4, 32'h45678337});
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_error"}, 64'(bus.error), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;
    reset = 1;
    bus.start = 0;
    bus.in_valid = 0;
    bus.in_data = 0;
    repeat (2) @(negedge clk);
    reset = 0;

    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);

    // stream 02 00 93 02 40 00 37 83 67 45, valid held high
    set_basic();
    build_stream(2);
    chk("stream_b2", 64'(sq[2]), 64'h93);
    chk("stream_b9", 64'(sq[9]), 64'h45);
    run_load(2, 0);
    check_basic("basic");

    tx_words.delete();
    run_load(0, 0);
    chk("empty_nwr", 64'(wlog.size()), 64'd0);
    chk("empty_done", 64'(bus.done), 64'd1);
    chk("empty_error", 64'(bus.error), 64'd0);

    set_basic();
    run_load(2, 40);
    check_basic("backpressure");

    tx_words.delete();
    for (int i = 1; i <= 5; i++) tx_words.push_back(32'h11111111 * i);
    run_load(5, 10);
    chk("ovf_nwr", 64'(wlog.size()), 64'd4);
    chk("ovf_wr0", wlog[0], {32'h0, 32'h11111111});
    chk("ovf_wr1", wlog[1], {32'h4, 32'h22222222});
    chk("ovf_wr2", wlog[2], {32'h8, 32'h33333333});
    chk("ovf_wr3", wlog[3], {32'hC, 32'h44444444});
    chk("ovf_error", 64'(bus.error), 64'd1);
    chk("ovf_done", 64'(bus.done), 64'd1);

    // abort after six bytes, then a fresh full load
    set_basic();
    build_stream(2);
    pulse_start();
    send_range(0, 6, 0);
    do_reset();
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    run_load(2, 0);
    check_basic("after_reset");

    // start pulse in the middle of the first word must be ignored
    set_basic();
    build_stream(2);
    wlog.delete();
    pulse_start();
    send_range(0, 4, 0);
    pulse_start();
    send_range(4, sq.size(), 0);
    wait_idle();
    check_basic("ignored_start");

    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 7);
      gap = $urandom_range(0, 50);
      tx_words.delete();
      for (int i = 0; i < n; i++) tx_words.push_back($urandom);
      run_load(n, gap);
      chk("rand_nwr", 64'(wlog.size()), 64'((n < NI) ? n : NI));
      chk("rand_error", 64'(bus.error), 64'(n > NI));
      chk("rand_done", 64'(bus.done), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
